// File: rtl/sonar_ranger_mc.sv
// Multi-channel ultrasonic ranger: triggers each sensor in turn, times the
// synchronized echo pulse in microseconds and reports the range in cm.
module sonar_ranger_mc #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int N_CH       = 2,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_US  = 60_000,
    parameter int TIMEOUT_US = 25_000,
    parameter int DIST_W     = 9
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    output logic [N_CH-1:0]                         trig,
    input  logic [N_CH-1:0]                         ech,
    output logic [N_CH*DIST_W-1:0]                  range_cm,
    output logic [N_CH-1:0]                         range_err,
    output logic                                    upd,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] upd_ch,
    output logic                                    busy
);

    localparam int TICK_DIV   = CLK_FREQ / 1_000_000;
    localparam int PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int US_MAX     = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int US_W       = $clog2(US_MAX + 1);
    localparam int PERIOD_CYC = PERIOD_US * TICK_DIV;
    localparam int PER_W      = $clog2(PERIOD_CYC + 1);
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_WAIT    = 3'd2,
        S_MEAS    = 3'd3,
        S_REPORT  = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [CH_W-1:0]   ch, ch_nx;
    logic [N_CH-1:0]   ech_s1, ech_s2;
    logic [PRE_W-1:0]  presc;
    logic [US_W-1:0]   us_cnt;
    logic [5:0]        div58;
    logic [DIST_W-1:0] cm_cnt;
    logic [PER_W-1:0]  per_cnt;
    logic              to_flag;
    logic              to_hit;
    logic              tick;
    logic              echo;
    logic              entering;
    logic [N_CH-1:0]   trig_nx;
    logic              busy_nx;
    logic              upd_nx;

    // One-hot select of a channel index.
    function automatic logic [N_CH-1:0] chan_mask(input logic [CH_W-1:0] c);
        logic [N_CH-1:0] m;
        m = '0;
        for (int k = 0; k < N_CH; k++) begin
            m[k] = (c == CH_W'(k));
        end
        return m;
    endfunction

    assign tick     = (presc == PRE_W'(TICK_DIV - 1));
    assign echo     = |(ech_s2 & chan_mask(ch));
    assign entering = (state_nx != state);

    // Two-flop synchronizer for the asynchronous echo inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ech_s1 <= '0;
            ech_s2 <= '0;
        end else begin
            ech_s1 <= ech;
            ech_s2 <= ech_s1;
        end
    end

    // State and active-channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ch    <= '0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
        end
    end

    // Next-state logic; an echo level always wins over a coincident timeout.
    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        to_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) state_nx = S_TRIG;
                else    state_nx = S_IDLE;
            end
            S_TRIG: begin
                if (tick && (us_cnt == US_W'(TRIG_US - 1))) state_nx = S_WAIT;
                else                                         state_nx = S_TRIG;
            end
            S_WAIT: begin
                if (echo) begin
                    state_nx = S_MEAS;
                end else if (tick && (us_cnt == US_W'(TIMEOUT_US - 1))) begin
                    state_nx = S_REPORT;
                    to_hit   = 1'b1;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_MEAS: begin
                if (!echo) begin
                    state_nx = S_REPORT;
                end else if (tick && (us_cnt == US_W'(TIMEOUT_US - 1))) begin
                    state_nx = S_REPORT;
                    to_hit   = 1'b1;
                end else begin
                    state_nx = S_MEAS;
                end
            end
            S_REPORT: state_nx = S_HOLD;
            S_HOLD: begin
                if (per_cnt >= PER_W'(PERIOD_CYC - 1)) begin
                    state_nx = en ? S_TRIG : S_IDLE;
                    ch_nx    = (ch == CH_W'(N_CH - 1)) ? CH_W'(0) : ch + CH_W'(1);
                end else begin
                    state_nx = S_HOLD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode, taken from the next state so the registered outputs line up with it.
    always_comb begin
        trig_nx = '0;
        if (state_nx == S_TRIG) trig_nx = chan_mask(ch_nx);
        else                    trig_nx = '0;
        busy_nx = (state_nx != S_IDLE);
        upd_nx  = (state == S_REPORT);
    end

    // Prescaler, microsecond, centimetre and period counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            us_cnt  <= '0;
            div58   <= '0;
            cm_cnt  <= '0;
            per_cnt <= '0;
            to_flag <= 1'b0;
        end else begin
            if (entering || tick) presc <= '0;
            else                  presc <= presc + PRE_W'(1);

            if (entering) us_cnt <= '0;
            else if (tick && (state == S_TRIG || state == S_WAIT || state == S_MEAS))
                us_cnt <= us_cnt + US_W'(1);

            if (entering && state_nx == S_MEAS) begin
                div58  <= '0;
                cm_cnt <= '0;
            end else if (state == S_MEAS && tick) begin
                if (div58 == 6'd57) begin
                    div58 <= '0;
                    if (cm_cnt != {DIST_W{1'b1}}) cm_cnt <= cm_cnt + DIST_W'(1);
                end else begin
                    div58 <= div58 + 6'd1;
                end
            end

            if (entering && state_nx == S_TRIG)       per_cnt <= '0;
            else if (per_cnt != PER_W'(PERIOD_CYC))  per_cnt <= per_cnt + PER_W'(1);

            if (entering && state_nx == S_REPORT) to_flag <= to_hit;
        end
    end

    // Registered outputs and per-channel result storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig      <= '0;
            busy      <= 1'b0;
            upd       <= 1'b0;
            upd_ch    <= '0;
            range_cm  <= '0;
            range_err <= '0;
        end else begin
            trig <= trig_nx;
            busy <= busy_nx;
            upd  <= upd_nx;
            if (state == S_REPORT) upd_ch <= ch;
            for (int k = 0; k < N_CH; k++) begin
                if (state == S_REPORT && ch == CH_W'(k)) begin
                    range_cm[k*DIST_W +: DIST_W] <= to_flag ? {DIST_W{1'b1}} : cm_cnt;
                    range_err[k]                 <= to_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_sonar_ranger_mc.sv
// Directed bench for sonar_ranger_mc: expected results are queued when a
// trigger is seen and checked by an independent monitor on every upd pulse.
module tb_sonar_ranger_mc;

    logic        clk = 1'b0;
    logic        rst, en, en_b;
    logic [1:0]  trig, ech, range_err, trig_b, ech_b, range_err_b;
    logic [17:0] range_cm;
    logic [7:0]  range_cm_b;
    logic        upd, busy, upd_b, busy_b;
    logic [0:0]  upd_ch, upd_ch_b;

    typedef struct {int ch; int cm; int err;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   total = 0, bad = 0, cyc = 0, upd_seen = 0;
    int   model_cm[2], model_err[2];
    int   rise_t[2];
    int   last_rise = -1, exp_rise_ch = 0;
    bit   chk_space = 1'b1;
    logic [1:0] trig_q = 2'b00;

    always #5 clk = ~clk;

    sonar_ranger_mc #(.CLK_FREQ(1_000_000), .N_CH(2), .TRIG_US(10), .PERIOD_US(2000),
                      .TIMEOUT_US(1000), .DIST_W(9)) dut (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .ech(ech), .range_cm(range_cm),
        .range_err(range_err), .upd(upd), .upd_ch(upd_ch), .busy(busy));

    sonar_ranger_mc #(.CLK_FREQ(1_000_000), .N_CH(2), .TRIG_US(10), .PERIOD_US(2000),
                      .TIMEOUT_US(2000), .DIST_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .trig(trig_b), .ech(ech_b), .range_cm(range_cm_b),
        .range_err(range_err_b), .upd(upd_b), .upd_ch(upd_ch_b), .busy(busy_b));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every upd pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (upd) begin
            upd_seen++;
            check("upd_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                model_cm[e.ch]  = e.cm;
                model_err[e.ch] = e.err;
                check("upd_ch", int'(upd_ch), e.ch);
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("range_cm%0d", k), int'(range_cm[k*9 +: 9]), model_cm[k]);
                    check($sformatf("range_err%0d", k), int'(range_err[k]), model_err[k]);
                end
            end
        end
    end

    // Trigger watcher: width, spacing, round-robin order and exclusivity.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (trig[k] && !trig_q[k]) begin
                check("trig_exclusive", int'(trig[1-k]), 0);
                check("rise_ch", k, exp_rise_ch);
                if (last_rise >= 0 && chk_space) check("trig_spacing", cyc - last_rise, 2000);
                exp_rise_ch <= (k == 0) ? 1 : 0;
                last_rise   <= cyc;
                rise_t[k]   <= cyc;
            end
            if (!trig[k] && trig_q[k]) check("trig_width", cyc - rise_t[k], 10);
        end
        trig_q <= trig;
    end

    task automatic wait_trig(input int k, input logic lvl);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (trig[k] == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("wait_trig%0d_%0d", k, lvl), int'(ok), 1);
    endtask

    task automatic measure(input int k, input int w, input int ecm, input int eerr);
        wait_trig(k, 1'b1);
        sb.push_back('{k, ecm, eerr});
        wait_trig(k, 1'b0);
        if (w > 0) begin
            repeat (5) @(negedge clk);
            ech[k] = 1'b1;
            repeat (w) @(negedge clk);
            ech[k] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; en_b = 1'b0; ech = 2'b00; ech_b = 2'b00;
        model_cm[0] = 0; model_cm[1] = 0; model_err[0] = 0; model_err[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_upd_ch", int'(upd_ch), 0);
        check("rst_range", int'(range_cm), 0);
        check("rst_err", int'(range_err), 0);
        rst = 1'b0;
        en  = 1'b1;

        measure(0, 580, 10, 0);
        // ch1: no echo, timeout after 1000 us in WAIT_ECHO
        wait_trig(1, 1'b1);
        sb.push_back('{1, 511, 1});
        wait_trig(1, 1'b0);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            if (upd) break;
        end
        check("wait_timeout_latency", n, 1001);
        measure(0, 1500, 511, 1);
        measure(1, 58, 1, 0);
        measure(0, 57, 0, 0);
        measure(1, 1000, 17, 0);
        measure(0, 1001, 511, 1);

        // ch1: en dropped mid-measurement, result still reported, then IDLE
        wait_trig(1, 1'b1);
        sb.push_back('{1, 3, 0});
        wait_trig(1, 1'b0);
        repeat (5) @(negedge clk);
        ech[1] = 1'b1;
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (150) @(negedge clk);
        ech[1] = 1'b0;
        repeat (1900) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_trig", int'(trig), 0);
        check("idle_sb_empty", sb.size(), 0);

        // restart on ch0, then reset during MEASURE
        chk_space = 1'b0;
        en = 1'b1;
        wait_trig(0, 1'b1);
        wait_trig(0, 1'b0);
        repeat (5) @(negedge clk);
        ech[0] = 1'b1;
        repeat (100) @(negedge clk);
        check("meas_busy", int'(busy), 1);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        ech[0] = 1'b0;
        check("midrst_trig", int'(trig), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_upd", int'(upd), 0);
        check("midrst_range", int'(range_cm), 0);
        check("midrst_err", int'(range_err), 0);
        model_cm[0] = 0; model_cm[1] = 0; model_err[0] = 0; model_err[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (1500) @(negedge clk);
        check("upd_count", upd_seen, 8);
        check("post_rst_busy", int'(busy), 0);

        // narrow range width: 1000 us echo saturates at 15 cm
        en_b = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (trig_b[0]) break;
        end
        en_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!trig_b[0]) break;
        end
        repeat (5) @(negedge clk);
        ech_b[0] = 1'b1;
        repeat (1000) @(negedge clk);
        ech_b[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (upd_b) break;
        end
        check("b_upd_seen", int'(upd_b), 1);
        check("b_range_sat", int'(range_cm_b[3:0]), 15);
        check("b_err", int'(range_err_b[0]), 0);
        check("b_upd_ch", int'(upd_ch_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
